// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory responder with valid/ready channels, programmable
//            wait states, byte-lane stores and out-of-range error reporting.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int         IDX_W  = ADDR_W - 2;
    localparam int         MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wen_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             accept;
    logic             access;
    logic             wr_en;
    logic             acc_wen;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic             acc_in_range;
    logic [MEM_AW-1:0] mem_idx;
    logic [31:0]      old_word;
    logic [31:0]      merged_word;
    logic             w_unused;

    // Byte offset bits carry no meaning for a word array.
    assign w_unused = ^req_addr[1:0];

    assign accept = (state_q == S_IDLE) && req_valid;
    assign access = (accept && (C_WAIT == 4'd0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));

    // Zero-wait accesses act on the live request; otherwise on the capture.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_wen   = req_wen;
            acc_idx   = req_addr[ADDR_W-1:2];
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_wen   = wen_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    // Full-width compare so high index bits are rejected, never wrapped.
    assign acc_in_range = (64'(acc_idx) < 64'(DEPTH_WORDS));
    assign mem_idx      = acc_idx[MEM_AW-1:0];
    assign old_word     = mem_q[mem_idx];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
                merged_word[8*i +: 8] = acc_wdata[8*i +: 8];
            end
        end
    end

    // Gating with reset keeps an asserted reset from ever touching the array.
    assign wr_en = access && acc_wen && acc_in_range && reset;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[mem_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d   = C_WAIT;
                    state_d = (C_WAIT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (access) begin
            err_d   = !acc_in_range;
            rdata_d = (acc_in_range && !acc_wen) ? old_word : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wen_q   <= req_wen;
                idx_q   <= req_addr[ADDR_W-1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed bench for data_mem_responder at WAIT_CYCLES = 1, 3, 0.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        reset     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wen   [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: WAIT_CYCLES=1, instance 1: WAIT_CYCLES=3, instance 2: WAIT_CYCLES=0.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        data_mem_responder #(
            .DEPTH_WORDS(1024),
            .WAIT_CYCLES(W),
            .ADDR_W     (32)
        ) u_dut (
            .clk      (clk),
            .reset    (reset[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_wen  (req_wen[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input int d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int lat);
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk); #1;
        check_val("txn_done", {30'd0, rsp_valid[d], req_ready[d]}, 32'd1);
    endtask

    task automatic txn_chk(input string tag, input int d, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        do_txn(d, wen, addr, wdata, be, rdata, err, lat);
        check_val({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check_val({tag, "_err"},   {31'd0, err}, {31'd0, exp_err});
        check_val({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    task automatic wait_rsp(input int d);
        int n;
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("rsp_wait", {31'd0, rsp_valid[d]}, 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            reset[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_wen[d]   = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_be[d]    = 4'd0;
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outputs", {27'd0, rsp_valid[0], rsp_err[0], busy[0], req_ready[0], |rsp_rdata[0]}, 32'h2);
        for (int d = 0; d < 3; d++) reset[d] = 1'b1;
        @(posedge clk); #1;

        // WAIT_CYCLES=1: basic store/load, byte lanes, range checks.
        txn_chk("st_full",  0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 2);
        txn_chk("ld_full",  0, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, 2);
        txn_chk("st_lane0", 0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'd0, 1'b0, 2);
        txn_chk("ld_lane0", 0, 1'b0, 32'h13, 32'd0, 4'hF, 32'hDEADBEAA, 1'b0, 2);
        txn_chk("st_be0",   0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0, 2);
        txn_chk("ld_be0",   0, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0, 2);
        txn_chk("st_w0",    0, 1'b1, 32'h0, 32'h0000CAFE, 4'hF, 32'd0, 1'b0, 2);
        txn_chk("st_last",  0, 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'd0, 1'b0, 2);
        txn_chk("st_oor",   0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'd0, 1'b1, 2);
        txn_chk("ld_w0",    0, 1'b0, 32'h0, 32'd0, 4'h0, 32'h0000CAFE, 1'b0, 2);
        txn_chk("ld_last",  0, 1'b0, 32'hFFC, 32'd0, 4'h0, 32'h0BADF00D, 1'b0, 2);
        txn_chk("ld_oor",   0, 1'b0, 32'h1000, 32'd0, 4'h0, 32'd0, 1'b1, 2);
        txn_chk("ld_hibit", 0, 1'b0, 32'h80000000, 32'd0, 4'h0, 32'd0, 1'b1, 2);

        // Back-pressure with a competing request held on the channel.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_wen[0]   = 1'b0;
        req_addr[0]  = 32'h10;
        @(posedge clk); #1;
        req_wen[0]   = 1'b1;
        req_wdata[0] = 32'd0;
        req_be[0]    = 4'hF;
        wait_rsp(0);
        for (int k = 0; k < 5; k++) begin
            check_val("bp_hold", {29'd0, rsp_valid[0], rsp_err[0], req_ready[0]}, 32'h4);
            check_val("bp_rdata", rsp_rdata[0], 32'hDEADBEAA);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release", {29'd0, rsp_valid[0], busy[0], req_ready[0]}, 32'h1);
        txn_chk("bp_after", 0, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0, 2);

        // WAIT_CYCLES=3: reset before the access abandons the store.
        txn_chk("w3_st",   1, 1'b1, 32'h20, 32'h11111111, 4'hF, 32'd0, 1'b0, 4);
        txn_chk("w3_ld",   1, 1'b0, 32'h20, 32'd0, 4'h0, 32'h11111111, 1'b0, 4);
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h55555555;
        req_be[1]    = 4'hF;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check_val("w3_busy", {31'd0, busy[1]}, 32'd1);
        @(posedge clk); #1;
        reset[1] = 1'b0;
        #1;
        check_val("w3_rst_out", {28'd0, rsp_valid[1], rsp_err[1], busy[1], req_ready[1]}, 32'h1);
        check_val("w3_rst_rdata", rsp_rdata[1], 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset[1] = 1'b1;
        @(posedge clk); #1;
        txn_chk("w3_ld_kept", 1, 1'b0, 32'h20, 32'd0, 4'h0, 32'h11111111, 1'b0, 4);

        // Reset while the response is pending keeps the completed store.
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b1;
        req_addr[1]  = 32'h24;
        req_wdata[1] = 32'h00000077;
        req_be[1]    = 4'hF;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(1);
        reset[1] = 1'b0;
        #1;
        check_val("resp_rst", {30'd0, rsp_valid[1], busy[1]}, 32'd0);
        @(posedge clk); #1;
        reset[1]     = 1'b1;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        txn_chk("resp_rst_ld", 1, 1'b0, 32'h24, 32'd0, 4'h0, 32'h00000077, 1'b0, 4);

        // WAIT_CYCLES=0: single-cycle latency and back-to-back streaming.
        txn_chk("w0_st", 2, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0, 1);
        txn_chk("w0_ld", 2, 1'b0, 32'h40, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0, 1);
        req_valid[2] = 1'b1;
        req_wen[2]   = 1'b0;
        req_addr[2]  = 32'h40;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check_val("w0_stream", {31'd0, rsp_valid[2]}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) check_val("w0_stream_rdata", rsp_rdata[2], 32'hA5A5A5A5);
        end
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        check_val("w0_idle", {30'd0, busy[2], req_ready[2]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
